poly_mul_responder: RTL and testbench

POLY_MUL_RESPONDER -- requirements
Module: poly_mul_responder

---
 rtl/poly_mul_responder.sv | 129 ++++++++++++
 tb/tb_poly_mul_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/poly_mul_responder.sv
// poly_mul_responder
//   Multiplies a degree-3 polynomial A (a0..a3) by a degree-1 polynomial B
//   (b0, b1). Coefficients are 4 bits and all arithmetic wraps mod 16.
//   The product is reduced mod (x^4 - 1) by default (cyclic). Defining the
//   macro NEGACYCLIC_EN switches to reduction mod (x^4 + 1) (negacyclic),
//   which negates the wrapped a3*b1 term in c0.
//   One output coefficient is produced per clock, in the order c0..c3.
//
// Ports
//   man_clk        rising-edge clock
//   man_reset      asynchronous, active-high reset
//   start          load/restart request; operands are captured on every
//                  clock edge where it is high
//   data0, data1   operand B coefficients b0, b1
//   ddata0..3      operand A coefficients a0..a3
//   w0..w3         registered product coefficients c0..c3
//   busy           high while the product is being computed
//   done           high while w0..w3 hold a complete product
module poly_mul_responder (
  input  logic       man_clk,
  input  logic       man_reset,
  input  logic       start,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic [3:0] ddata0,
  input  logic [3:0] ddata1,
  input  logic [3:0] ddata2,
  input  logic [3:0] ddata3,
  output logic [3:0] w0,
  output logic [3:0] w1,
  output logic [3:0] w2,
  output logic [3:0] w3,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] idx;
  logic [3:0] a_reg [0:3];
  logic [3:0] b0_reg;
  logic [3:0] b1_reg;
  logic [3:0] w_reg [0:3];

  logic [3:0] cur_a;
  logic [3:0] prev_a;
  logic       neg_term;
  logic [3:0] c_next;

  // Mod-16 multiply-accumulate: low nibble of x*y plus (or minus) the low
  // nibble of u*v, wrapped to 4 bits.
  function automatic logic [3:0] wrap_mac(input logic [3:0] x,
                                          input logic [3:0] y,
                                          input logic [3:0] u,
                                          input logic [3:0] v,
                                          input logic       neg);
    logic [7:0] p;
    logic [7:0] q;
    p = {4'd0, x} * {4'd0, y};
    q = {4'd0, u} * {4'd0, v};
    if (neg) wrap_mac = p[3:0] - q[3:0];
    else     wrap_mac = p[3:0] + q[3:0];
  endfunction

  // idx - 1 wraps from 0 to 3, which is exactly the a3 term that folds
  // back into c0 under the x^4 reduction.
  always_comb begin
    cur_a  = a_reg[idx];
    prev_a = a_reg[idx - 2'd1];
`ifdef NEGACYCLIC_EN
    neg_term = (idx == 2'd0);
`else
    neg_term = 1'b0;
`endif
    c_next = wrap_mac(cur_a, b0_reg, prev_a, b1_reg, neg_term);
  end

  always_ff @(posedge man_clk or posedge man_reset) begin
    if (man_reset) begin
      state  <= IDLE;
      idx    <= 2'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      b0_reg <= 4'd0;
      b1_reg <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        a_reg[i] <= 4'd0;
        w_reg[i] <= 4'd0;
      end
    end else if (start) begin
      // Capture (or re-capture) from any state; a partial result is dropped.
      state    <= COMP;
      idx      <= 2'd0;
      busy     <= 1'b1;
      done     <= 1'b0;
      a_reg[0] <= ddata0;
      a_reg[1] <= ddata1;
      a_reg[2] <= ddata2;
      a_reg[3] <= ddata3;
      b0_reg   <= data0;
      b1_reg   <= data1;
      for (int i = 0; i < 4; i++) w_reg[i] <= 4'd0;
    end else begin
      case (state)
        COMP: begin
          w_reg[idx] <= c_next;
          idx        <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;  // IDLE and DONE hold until the next start
      endcase
    end
  end

  assign w0 = w_reg[0];
  assign w1 = w_reg[1];
  assign w2 = w_reg[2];
  assign w3 = w_reg[3];

endmodule

// File: tb/tb_poly_mul_responder.sv
// tb_poly_mul_responder
//   Randomized and directed bench for poly_mul_responder. Expected products
//   come from a convolution model over all a_i*b_j pairs with x^4 folding.
//   Honours NEGACYCLIC_EN the same way as the design.
module tb_poly_mul_responder;

  logic       man_clk;
  logic       man_reset;
  logic       start;
  logic [3:0] data0, data1;
  logic [3:0] ddata0, ddata1, ddata2, ddata3;
  logic [3:0] w0, w1, w2, w3;
  logic       busy, done;

  int n_checks;
  int n_fails;

  poly_mul_responder dut (
    .man_clk  (man_clk),
    .man_reset(man_reset),
    .start    (start),
    .data0    (data0),
    .data1    (data1),
    .ddata0   (ddata0),
    .ddata1   (ddata1),
    .ddata2   (ddata2),
    .ddata3   (ddata3),
    .w0       (w0),
    .w1       (w1),
    .w2       (w2),
    .w3       (w3),
    .busy     (busy),
    .done     (done)
  );

  initial man_clk = 1'b0;
  always #5 man_clk = ~man_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] w_bus();
    return {w3, w2, w1, w0};
  endfunction

  // Product of A and B reduced mod x^4 -/+ 1, coefficients mod 16.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [7:0] b);
    int c [4];
    logic [15:0] r;
    for (int k = 0; k < 4; k++) c[k] = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++) begin
        int t;
        t = int'(a[i*4 +: 4]) * int'(b[j*4 +: 4]);
`ifdef NEGACYCLIC_EN
        if (i + j >= 4) c[(i + j) % 4] -= t;
        else            c[(i + j) % 4] += t;
`else
        c[(i + j) % 4] += t;
`endif
      end
    end
    for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'(c[k] & 15);
    return r;
  endfunction

  task automatic drive_ops(input logic [15:0] a, input logic [7:0] b);
    ddata0 = a[3:0];  ddata1 = a[7:4];  ddata2 = a[11:8];  ddata3 = a[15:12];
    data0  = b[3:0];  data1  = b[7:4];
  endtask

  task automatic scramble_ops();
    drive_ops(16'($urandom), 8'($urandom));
  endtask

  // One-cycle start, then check progress each cycle and the held result.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
    @(negedge man_clk);
    drive_ops(a, b);
    start = 1'b1;
    @(negedge man_clk);
    start = 1'b0;
    scramble_ops();
    check({tag, "_cap_busy"}, busy, 1'b1);
    check({tag, "_cap_w"}, w_bus(), 16'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge man_clk);
      scramble_ops();
      if (k < 4) check({tag, "_done_early"}, done, 1'b0);
    end
    check({tag, "_w"}, w_bus(), exp);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    repeat (3) begin
      @(negedge man_clk);
      scramble_ops();
    end
    check({tag, "_hold_w"}, w_bus(), exp);
    check({tag, "_hold_done"}, done, 1'b1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    n_checks  = 0;
    n_fails   = 0;
    start     = 1'b0;
    man_reset = 1'b1;
    drive_ops(16'h0, 8'h0);
    repeat (2) @(negedge man_clk);
    check("rst_w", w_bus(), 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    man_reset = 1'b0;
    repeat (3) begin
      @(negedge man_clk);
      scramble_ops();
    end
    check("idle_w", w_bus(), 16'h0);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);

    // A=(1,2,3,4) B=(3,1)
`ifdef NEGACYCLIC_EN
    run_mul("basic", 16'h4321, 8'h13, 16'hFB7F);
    run_mul("all15", 16'hFFFF, 8'hFF, 16'h2220);
`else
    run_mul("basic", 16'h4321, 8'h13, 16'hFB77);
    run_mul("all15", 16'hFFFF, 8'hFF, 16'h2222);
`endif

    // Restart at idx==2 with A=(1,0,0,0) B=(5,0)
    @(negedge man_clk);
    drive_ops(16'h4321, 8'h13);
    start = 1'b1;
    @(negedge man_clk);
    start = 1'b0;
    repeat (2) @(negedge man_clk);
    drive_ops(16'h0001, 8'h05);
    start = 1'b1;
    @(negedge man_clk);
    start = 1'b0;
    scramble_ops();
    check("restart_w_clr", w_bus(), 16'h0);
    check("restart_done", done, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge man_clk);
      scramble_ops();
      if (k < 4) check("restart_done_early", done, 1'b0);
    end
    check("restart_w", w_bus(), 16'h0005);
    check("restart_done_end", done, 1'b1);

    // Asynchronous reset in the middle of a computation
    @(negedge man_clk);
    drive_ops(16'h4321, 8'h13);
    start = 1'b1;
    @(negedge man_clk);
    start = 1'b0;
    repeat (2) @(posedge man_clk);
    #2 man_reset = 1'b1;
    start = 1'b1;
    #1;
    check("areset_w", w_bus(), 16'h0);
    check("areset_busy", busy, 1'b0);
    check("areset_done", done, 1'b0);
    @(negedge man_clk);
    check("areset_ignore_start", busy, 1'b0);
    start = 1'b0;
    man_reset = 1'b0;
    repeat (2) @(negedge man_clk);
    check("post_reset_idle", busy, 1'b0);
    check("post_reset_w", w_bus(), 16'h0);
    run_mul("post_reset", 16'h4321, 8'h13, model(16'h4321, 8'h13));

    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      run_mul($sformatf("rand%0d", n), ra, rb, model(ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
